// File: rtl/sa_driver.sv
// sa_driver: feeds a parallel operand pair bit-serially (LSB first) to an external serial adder and reassembles the sum.
//   clk, rst                    : clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b : parallel operand handshake (accepted only in IDLE)
//   res_valid/res_ready         : result handshake, held in DONE until res_ready
//   res_sum/res_cout            : parallel sum, carry out (tied 0 unless SA_DRIVER_CARRY_OUT_EN)
//   sa_a/sa_b/sa_rst/sa_out     : serial adder operand bits, carry clear pulse, returned sum bit
//   Optional macro SA_DRIVER_CARRY_OUT_EN shifts one extra zero bit and returns its sum bit as res_cout.
module sa_driver #(
    parameter int WIDTH  = 4,
    parameter int SA_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             sa_a,
    output logic             sa_b,
    output logic             sa_rst,
    input  logic             sa_out
);
`ifdef SA_DRIVER_CARRY_OUT_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int CW = $clog2(NB + SA_LAT + 1);
    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [NB-1:0]    acc_q, acc_d;
    logic             busy, last, samp_ok;
    assign busy = (state_q == SHIFT) || (state_q == DRAIN);
    // cnt_q runs through SHIFT and DRAIN; the final sample closes the operation
    assign last = cnt_q == CW'(NB + SA_LAT - 1);
    // sum bit k returns SA_LAT cycles after operand bit k was driven
    if (SA_LAT == 0) begin : g_lat0
        assign samp_ok = 1'b1;
    end else begin : g_lat
        assign samp_ok = cnt_q >= CW'(SA_LAT);
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = busy ? cnt_q + 1'b1 : '0;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = CLR;
                a_d     = in_a;
                b_d     = in_b;
            end
            CLR:   state_d = SHIFT;
            // operands shift right so bit 0 is always the one on the wire; zeros fill the extra carry bit
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                state_d = last ? DONE : (cnt_q == CW'(NB - 1)) ? DRAIN : SHIFT;
            end
            DRAIN: state_d = last ? DONE : DRAIN;
            DONE:  state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (busy && samp_ok)
            acc_d = {sa_out, acc_q[NB-1:1]};
        if (busy && last)
            sum_d = acc_d[WIDTH-1:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
        end
    end
`ifdef SA_DRIVER_CARRY_OUT_EN
    logic cout_q, cout_d;
    always_comb cout_d = (busy && last) ? acc_d[WIDTH] : cout_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cout_q <= 1'b0;
        else     cout_q <= cout_d;
    end
    assign res_cout = cout_q;
`else
    assign res_cout = 1'b0;
`endif
    assign in_ready  = state_q == IDLE;
    assign res_valid = state_q == DONE;
    assign res_sum   = sum_q;
    assign sa_rst    = state_q == CLR;
    assign sa_a      = (state_q == SHIFT) & a_q[0];
    assign sa_b      = (state_q == SHIFT) & b_q[0];
endmodule

// File: tb/tb_sa_driver.sv
// tb_sa_driver: scoreboard bench for sa_driver with ideal serial adders at SA_LAT 0, 1 and 2.
module tb_sa_driver;
`ifdef SA_DRIVER_CARRY_OUT_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    typedef struct {
        logic [4:0] res;
        int         acc;
    } item_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] iv = '0, rr = 3'b111;
    logic [2:0] rdy, rv, rc, sa_a_w, sa_b_w, sa_rst_w, sa_out_w;
    logic [3:0] ina = '0, inb = '0;
    logic [3:0] rs [3];
    bit   [2:0] carry;
    bit   [1:0] pipe [3];
    item_t      sb [$];
    int         n_tests = 0, n_fail = 0, cyc = 0, n_acc = 0, n_res = 0, vcyc = 0;
    bit         vseen = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        sa_driver #(.WIDTH(4), .SA_LAT(g)) u_dut (
            .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(rdy[g]), .in_a(ina), .in_b(inb),
            .res_valid(rv[g]), .res_ready(rr[g]), .res_sum(rs[g]), .res_cout(rc[g]),
            .sa_a(sa_a_w[g]), .sa_b(sa_b_w[g]), .sa_rst(sa_rst_w[g]), .sa_out(sa_out_w[g])
        );
    end
    // ideal serial adders: carry cleared by sa_rst, sum bit delayed by 0, 1 or 2 cycles
    always @(posedge clk)
        for (int i = 0; i < 3; i++) begin
            carry[i] <= sa_rst_w[i] ? 1'b0 : (sa_a_w[i] & sa_b_w[i]) | (carry[i] & (sa_a_w[i] ^ sa_b_w[i]));
            pipe[i]  <= {pipe[i][0], sa_a_w[i] ^ sa_b_w[i] ^ carry[i]};
        end
    assign sa_out_w = {pipe[2][1], pipe[1][0], sa_a_w[0] ^ sa_b_w[0] ^ carry[0]};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // scoreboard monitor on the SA_LAT=1 instance
    always @(negedge clk) begin
        if (rst) vseen = 1'b0;
        else begin
            if (iv[1] && rdy[1]) begin
                logic [4:0] full;
                full = {1'b0, ina} + {1'b0, inb};
                sb.push_back('{res: {(NB > 4) & full[4], full[3:0]}, acc: cyc});
                n_acc++;
            end
            if (rv[1] && !vseen) begin
                vseen = 1'b1;
                vcyc  = cyc;
            end
            if (rv[1] && rr[1]) begin
                if (sb.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    item_t it;
                    it = sb.pop_front();
                    chk("sum_cout", {rc[1], rs[1]}, it.res);
                    chk("latency", vcyc - it.acc - 1, 1 + NB + 1);
                end
                vseen = 1'b0;
                n_res++;
            end
        end
    end
    task automatic send(input logic [3:0] a, input logic [3:0] b);
        int t = 0;
        ina   = a;
        inb   = b;
        iv[1] = 1'b1;
        while (!rdy[1] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("accept_ready", rdy[1], 1);
        @(posedge clk); #1;
        iv[1] = 1'b0;
    endtask
    task automatic wait_done();
        int t = 0;
        while ((sb.size() != 0 || !rdy[1]) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb.size(), 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [9:0] tr;
        logic       any;
        int         a0, r0, t;
        int         lat [3];
        logic [3:0] sum2 [3];
        #7;
        chk("rst_outputs", {rv[1], rs[1], rc[1], sa_a_w[1], sa_b_w[1], sa_rst_w[1]}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", rdy[1], 1);
        @(posedge clk); #1;
        send(4'b0101, 4'b0011);
        tr = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tr = {tr[7:0], sa_rst_w[1], sa_a_w[1]};
        end
        chk("clr_then_lsb_first", tr, 10'b10_01_00_01_00);
        wait_done();
        send(4'b1111, 4'b0001);
        wait_done();
        rr[1] = 1'b0;
        send(4'b1001, 4'b0100);
        t = 0;
        while (!rv[1] && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("bp_reach_done", rv[1], 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", {rv[1], rdy[1], rs[1]}, {2'b10, 4'b1101});
        end
        @(posedge clk); #1;
        rr[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release", {rv[1], rdy[1]}, 2'b01);
        chk("sum_retained", rs[1], 4'b1101);
        send(4'b0111, 4'b0001);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_abort", {rv[1], rs[1], rc[1], sa_a_w[1], sa_b_w[1], sa_rst_w[1]}, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            any |= rv[1];
        end
        chk("no_result_after_abort", any, 0);
        @(posedge clk); #1;
        send(4'b0010, 4'b0010);
        @(negedge clk);
        chk("clr_after_rst", sa_rst_w[1], 1);
        wait_done();
        a0 = n_acc;
        r0 = n_res;
        iv[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            ina = 4'($urandom);
            inb = 4'($urandom);
        end
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            ina   = 4'($urandom);
            inb   = 4'($urandom);
            iv[1] = 1'($urandom_range(0, 1));
            rr[1] = 1'($urandom_range(0, 1));
        end
        iv[1] = 1'b0;
        rr[1] = 1'b1;
        wait_done();
        chk("several_accepts", (n_acc - a0) > 5, 1);
        chk("one_result_per_accept", n_res - r0, n_acc - a0);
        ina   = 4'b0110;
        inb   = 4'b0111;
        lat[0] = -1;
        lat[2] = -1;
        iv[0] = 1'b1;
        iv[2] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        iv[2] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g += 2)
                if (rv[g] && lat[g] < 0) begin
                    lat[g]  = k - 1;
                    sum2[g] = rs[g];
                end
        end
        chk("lat0_latency", lat[0], 1 + NB);
        chk("lat0_sum", sum2[0], 4'b1101);
        chk("lat2_latency", lat[2], 3 + NB);
        chk("lat2_sum", sum2[2], 4'b1101);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sa_driver.md
SA_DRIVER -- requirements
Module: sa_driver

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits, legal range 2..16.
REQ-002 Parameter SA_LAT, default 1: cycles from a bit driven on sa_a/sa_b to its sum bit valid on sa_out, legal range 0..2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  parallel operand pair offered.
REQ-006 in_ready  output  1  block accepts operands.
REQ-007 in_a, in_b  input  WIDTH each  parallel operands.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer accepts result.
REQ-010 res_sum  output  WIDTH  parallel sum.
REQ-011 res_cout  output  1  carry out; behaviour per REQ-031/032.
REQ-012 sa_a, sa_b  output  1 each  serial operand bits to the serial adder, LSB first.
REQ-013 sa_rst  output  1  active-high clear pulse to the serial adder's carry.
REQ-014 sa_out  input  1  serial sum bit from the serial adder.

Function
REQ-015 The FSM SHALL have states IDLE, CLR, SHIFT, DRAIN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; an accept occurs when in_valid and in_ready are both 1, which latches in_a/in_b and moves the FSM to CLR.
REQ-017 in_valid outside IDLE SHALL be ignored, with no latch and no state change.
REQ-018 CLR SHALL last exactly one cycle with sa_rst=1, sa_a=0 and sa_b=0, then move to SHIFT; sa_rst SHALL be 0 in every other state.
REQ-019 SHIFT SHALL last NB cycles (NB=WIDTH, or WIDTH+1 per REQ-031), driving latched bit k on sa_a/sa_b in SHIFT cycle k, k=0..NB-1, with bit index WIDTH driven as 0.
REQ-020 The sum bit for position k SHALL be sampled from sa_out at SHIFT cycle k+SA_LAT, counting on into DRAIN, and stored into result bit k.
REQ-021 DRAIN SHALL last SA_LAT cycles, or zero cycles when SA_LAT=0, with sa_a=sa_b=0, then move to DONE.
REQ-022 DONE SHALL hold res_valid=1 and stable res_sum/res_cout until res_ready=1, then move to IDLE on the next edge.
REQ-023 Latency from accept edge to res_valid SHALL be 1+NB+SA_LAT cycles, which is 6 for the defaults without the macro.
REQ-024 res_sum/res_cout SHALL retain their last value after DONE until the next capture overwrites them; res_valid SHALL be 0 outside DONE.
REQ-025 The bit counter SHALL be wide enough for NB+SA_LAT without wrap.
REQ-026 Sum arithmetic SHALL be modulo 2^WIDTH; overflow is visible only via res_cout when enabled.

Reset
REQ-027 While rst=1, the FSM SHALL be in IDLE, and in_ready SHALL be 1 after rst deasserts.
REQ-028 While rst=1, res_valid=0, res_sum=0, res_cout=0, sa_a=0, sa_b=0, sa_rst=0 and the counter SHALL be 0.
REQ-029 rst asserted in any state, including mid-SHIFT, SHALL abort the operation with no res_valid for it.
REQ-030 After deassertion, the next operation SHALL still pass through CLR.

Configuration
REQ-031 With macro SA_DRIVER_CARRY_OUT_EN defined, NB=WIDTH+1: one extra zero bit is shifted, and its sampled sum bit SHALL drive res_cout.
REQ-032 Without SA_DRIVER_CARRY_OUT_EN, NB=WIDTH, res_cout SHALL be tied to 0 and the port SHALL remain present.

Verification
REQ-033 in_a=0101, in_b=0011, defaults, ideal serial adder -> sa_rst pulse, sa_a LSB-first 1,0,1,0; res_valid 6 cycles after accept; res_sum=1000.
REQ-034 in_a=1111, in_b=0001 -> res_sum=0000; res_cout=1 with the macro, in which case res_valid comes 7 cycles after accept; res_cout=0 without the macro.
REQ-035 res_ready held 0 for 10 cycles in DONE -> res_valid and res_sum stay stable and in_ready stays 0; res_ready=1 -> IDLE with in_ready=1 next cycle.
REQ-036 rst pulsed in the 2nd SHIFT cycle -> all outputs 0 immediately and no res_valid; the following op 0010+0010 -> res_sum=0100.
REQ-037 in_valid held high continuously with new operands every accept, with in_valid toggled during busy -> exactly one result per accept and busy-time operands dropped.
REQ-038 SA_LAT=0 and SA_LAT=2 builds with 0110+0111 -> res_sum=1101 at 5 and 7 cycles after accept respectively.
